// File: rtl/ysyx_210544_cache_arbiter_pkg.sv
// Shared constants and types for the IF/MEM cache-core arbiter.
package ysyx_210544_cache_arbiter_pkg;

  localparam int   BUS_64   = 64;
  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GNT_IF  = 2'd1,
    ST_GNT_MEM = 2'd2,
    ST_RECOVER = 2'd3
  } arb_state_t;

  // One latched core access, whichever port it came from.
  typedef struct packed {
    logic              op;
    logic [BUS_64-1:0] addr;
    logic [BUS_64-1:0] wdata;
    logic [2:0]        bytes;
  } core_req_t;

endpackage

// File: rtl/ysyx_210544_arb_starve_cnt.sv
// Counts MEM grants taken while IF waits; flags when IF must win the next tie.
module ysyx_210544_arb_starve_cnt #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic force_if
);

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (inc && cnt != LIM)
      cnt <= cnt + 4'd1;
  end

  assign force_if = (cnt == LIM);

endmodule

// File: rtl/ysyx_210544_cache_arbiter.sv
// Time-shares the cache core between IF (read-only) and MEM (read/write) ports.
import ysyx_210544_cache_arbiter_pkg::*;

module ysyx_210544_cache_arbiter #(
  parameter bit MEM_PRIORITY = 1'b1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_hold,
  input  logic              i_if_req,
  input  logic [BUS_64-1:0] i_if_addr,
  input  logic [2:0]        i_if_bytes,
  output logic [BUS_64-1:0] o_if_rdata,
  output logic              o_if_ack,
  input  logic              i_mem_req,
  input  logic              i_mem_op,
  input  logic [BUS_64-1:0] i_mem_addr,
  input  logic [BUS_64-1:0] i_mem_wdata,
  input  logic [2:0]        i_mem_bytes,
  output logic [BUS_64-1:0] o_mem_rdata,
  output logic              o_mem_ack,
  output logic              o_core_req,
  output logic              o_core_op,
  output logic [BUS_64-1:0] o_core_addr,
  output logic [BUS_64-1:0] o_core_wdata,
  output logic [2:0]        o_core_bytes,
  input  logic [BUS_64-1:0] i_core_rdata,
  input  logic              i_core_ack
);

  arb_state_t state;
  core_req_t  cur, if_pkt, mem_pkt;
  logic       force_if, pick_if, pick_mem;

  always_comb begin
    if_pkt.op      = OP_READ;
    if_pkt.addr    = i_if_addr;
    if_pkt.wdata   = '0;
    if_pkt.bytes   = i_if_bytes;
    mem_pkt.op     = i_mem_op;
    mem_pkt.addr   = i_mem_addr;
    mem_pkt.wdata  = i_mem_wdata;
    mem_pkt.bytes  = i_mem_bytes;
    pick_if        = 1'b0;
    pick_mem       = 1'b0;
    if (state == ST_IDLE && !i_hold) begin
      if (i_if_req && i_mem_req) begin
        if (force_if || !MEM_PRIORITY) pick_if  = 1'b1;
        else                            pick_mem = 1'b1;
      end else begin
        pick_if  = i_if_req;
        pick_mem = i_mem_req;
      end
    end
  end

  // IF not waiting in IDLE means it is not being starved any more.
  ysyx_210544_arb_starve_cnt #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
    .clk      (clk),
    .rst      (rst),
    .clr      (pick_if || (state == ST_IDLE && !i_if_req)),
    .inc      (pick_mem && i_if_req),
    .force_if (force_if)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cur         <= '0;
      o_core_req  <= 1'b0;
      o_if_ack    <= 1'b0;
      o_mem_ack   <= 1'b0;
      o_if_rdata  <= '0;
      o_mem_rdata <= '0;
    end else begin
      o_if_ack  <= 1'b0;
      o_mem_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_if || pick_mem) begin
            cur        <= pick_if ? if_pkt : mem_pkt;
            o_core_req <= 1'b1;
            state      <= pick_if ? ST_GNT_IF : ST_GNT_MEM;
          end
        end
        ST_GNT_IF: begin
          if (i_core_ack) begin
            o_core_req <= 1'b0;
            o_if_rdata <= i_core_rdata;
            o_if_ack   <= 1'b1;
            state      <= ST_RECOVER;
          end
        end
        ST_GNT_MEM: begin
          if (i_core_ack) begin
            o_core_req  <= 1'b0;
            o_mem_rdata <= i_core_rdata;
            o_mem_ack   <= 1'b1;
            state       <= ST_RECOVER;
          end
        end
        // Core needs one request-free cycle to drop its ack before the next grant.
        ST_RECOVER: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  assign o_core_op    = cur.op;
  assign o_core_addr  = cur.addr;
  assign o_core_wdata = cur.wdata;
  assign o_core_bytes = cur.bytes;

endmodule

// File: doc/ysyx_210544_cache_arbiter.md
Name: ysyx_210544_cache_arbiter

Overview:
Shares one unaligned-capable cache core (req/ack, addr/wdata/bytes/op) between the instruction-fetch port (read-only) and the memory-stage port (read/write). Grants one requester at a time, latches its request, sequences the core handshake, and routes rdata/ack back. Adds an anti-starvation counter for IF and a hold input that stalls new grants while the cache sync channel is active.

Parameters:
MEM_PRIORITY, 1, 1: MEM wins simultaneous requests; 0: IF wins
STARVE_LIMIT, 4, consecutive MEM grants with IF pending before IF is forced (1..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
i_hold  in  1  block new grants (sync channel busy); in-flight access completes
i_if_req  in  1  IF request, held until o_if_ack
i_if_addr  in  64  IF byte address
i_if_bytes  in  3  IF byte count minus 1
o_if_rdata  out  64  IF read data, valid with o_if_ack
o_if_ack  out  1  one-cycle IF completion pulse
i_mem_req  in  1  MEM request, held until o_mem_ack
i_mem_op  in  1  0 read, 1 write
i_mem_addr  in  64  MEM byte address
i_mem_wdata  in  64  MEM write data
i_mem_bytes  in  3  MEM byte count minus 1
o_mem_rdata  out  64  MEM read data, valid with o_mem_ack
o_mem_ack  out  1  one-cycle MEM completion pulse
o_core_req  out  1  request to cache core
o_core_op  out  1  op to core
o_core_addr  out  64  address to core
o_core_wdata  out  64  write data to core
o_core_bytes  out  3  byte count to core
i_core_rdata  in  64  core read data
i_core_ack  in  1  core completion

Behaviour:
- Reset: state IDLE; all outputs 0; starve counter 0; grant owner cleared.
- States: IDLE, GNT_IF, GNT_MEM, RECOVER. All outputs registered.
- IDLE: if i_hold=1, stay, core req 0. Otherwise arbitrate on sampled reqs:
  - only one req -> grant it.
  - both -> if starve_cnt==STARVE_LIMIT grant IF; else per MEM_PRIORITY.
  - on grant latch addr/bytes/wdata/op into o_core_* (IF: op=0, wdata=0), set o_core_req=1 next cycle, enter GNT_x.
- GNT_x: o_core_req held 1, o_core_* stable. On cycle where i_core_ack=1: next cycle o_core_req=0, o_x_rdata<=i_core_rdata, o_x_ack=1 (exactly one cycle), enter RECOVER. i_core_ack outside GNT_x ignored.
- RECOVER: exactly one cycle with o_core_req=0 so core clears its ack/index before any new request; then IDLE. The next grant cannot issue in RECOVER.
- Requester contract: drops req on the edge it samples ack; arbiter does not re-sample reqs until IDLE.
- Latency overhead: req sampled in IDLE at edge n -> o_core_req high from n+1; core ack at edge k -> o_x_ack high in cycle k+1; next grant earliest k+3.
- o_x_rdata holds last value until next completion for that port.
- starve_cnt: +1 (saturating at STARVE_LIMIT) on each MEM grant while i_if_req=1; cleared on IF grant or when i_if_req=0 in IDLE.
- i_hold asserted mid-access: no effect on the in-flight access; only blocks the IDLE grant.
- Requester deasserting req before ack (protocol violation): access still completes on core; ack still pulsed.
- rst mid-access: immediate return to IDLE, no ack emitted; core is reset by the same rst.

Decomposition:
- Shared defines header: state encodings, OP_READ/OP_WRITE constants, BUS_64 width macro.
- One natural sub-module: ysyx_210544_arb_starve_cnt (saturating counter + force flag); the rest is a single FSM.

Test Plan:
- IF-only read addr 0x8000_0000, bytes=3, core acks after 5 cycles with rdata 0x1234 -> o_if_ack one pulse, o_if_rdata=0x1234, o_core_op=0, RECOVER one cycle with o_core_req=0.
- Simultaneous IF and MEM write (addr 0x8000_1008, wdata 0xDEAD_BEEF, bytes=7), MEM_PRIORITY=1 -> MEM granted first, o_core_op=1; IF granted after RECOVER; both get exactly one ack.
- Starvation: MEM re-requests back-to-back, IF held high, STARVE_LIMIT=4 -> 4 MEM grants, 5th grant to IF, counter back to 0.
- i_hold=1 with IF pending for 10 cycles -> o_core_req stays 0; hold drops -> grant next cycle. Hold raised during GNT_MEM -> access completes normally.
- Spurious i_core_ack in IDLE/RECOVER -> no ack to either port, rdata unchanged.
- rst asserted in GNT_IF before core ack -> next cycle all outputs 0, state IDLE, no o_if_ack.
